// File: rtl/sprite_pkg.sv
// Shared definitions for the sprite plotter: sprite IDs in request-priority
// order, screen and sprite dimensions, and the plotter state encoding.
package sprite_pkg;

    localparam int unsigned ScreenW = 160;
    localparam int unsigned ScreenH = 120;

    localparam int unsigned FullW   = 160;
    localparam int unsigned FullH   = 120;
    localparam int unsigned BubbleW = 32;
    localparam int unsigned BubbleH = 32;
    localparam int unsigned ItemW   = 16;
    localparam int unsigned ItemH   = 16;

    localparam int unsigned NumReq  = 13;

    // Lower value wins when several requests are high at once.
    typedef enum logic [3:0] {
        SprStart    = 4'd0,
        SprBg       = 4'd1,
        SprHunger   = 4'd2,
        SprBored    = 4'd3,
        SprSick     = 4'd4,
        SprDirty    = 4'd5,
        SprDying    = 4'd6,
        SprZzzs     = 4'd7,
        SprFood     = 4'd8,
        SprPills    = 4'd9,
        SprFirstAid = 4'd10,
        SprBroom    = 4'd11,
        SprBall     = 4'd12
    } sprite_id_e;

    typedef enum logic [2:0] {
        StIdle,
        StRun,
        StFlush,
        StDone,
        StRelease
    } plot_state_e;

endpackage

// File: rtl/sprite_geom.sv
// Combinational sprite geometry lookup.
//   id_i              sprite ID
//   obj_x_i/obj_y_i   item position (used only for item sprites)
//   width_o/height_o  sprite size in pixels
//   base_x_o/base_y_o top-left screen position
//   opaque_o          full-screen sprite: the transparent key is plotted
module sprite_geom
    import sprite_pkg::*;
#(
    parameter int unsigned BUBBLE_X = 100,
    parameter int unsigned BUBBLE_Y = 20
) (
    input  sprite_id_e  id_i,
    input  logic [7:0]  obj_x_i,
    input  logic [6:0]  obj_y_i,
    output logic [7:0]  width_o,
    output logic [6:0]  height_o,
    output logic [7:0]  base_x_o,
    output logic [6:0]  base_y_o,
    output logic        opaque_o
);

    always_comb begin
        width_o  = 8'(ItemW);
        height_o = 7'(ItemH);
        base_x_o = obj_x_i;
        base_y_o = obj_y_i;
        opaque_o = 1'b0;
        if (id_i <= SprBg) begin
            width_o  = 8'(FullW);
            height_o = 7'(FullH);
            base_x_o = 8'd0;
            base_y_o = 7'd0;
            opaque_o = 1'b1;
        end else if (id_i <= SprZzzs) begin
            width_o  = 8'(BubbleW);
            height_o = 7'(BubbleH);
            base_x_o = 8'(BUBBLE_X);
            base_y_o = 7'(BUBBLE_Y);
        end
    end

endmodule

// File: rtl/sprite_plotter.sv
// Sprite plotter: serves one of thirteen level-held draw requests by walking
// the sprite's pixels out of the sprite ROM and writing them to the VGA
// adapter, then pulsing plot_done for one cycle.
//   clk, reset                sync active-high reset
//   draw_*_s                  level-held draw requests (ID order 0..12)
//   obj_x, obj_y              item top-left, sampled when a request is accepted
//   rom_sel, rom_addr         sprite ROM read port (data one cycle later)
//   rom_data                  sprite ROM output
//   vga_x/vga_y/vga_colour    VGA adapter pixel write, strobed by vga_plot
//   plot_done                 one-cycle completion pulse
//   busy                      high whenever not idle
module sprite_plotter
    import sprite_pkg::*;
#(
    parameter int unsigned                COLOUR_W    = 9,
    parameter int unsigned                BUBBLE_X    = 100,
    parameter int unsigned                BUBBLE_Y    = 20,
    parameter logic [COLOUR_W-1:0]        TRANSPARENT = 9'h1FF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                draw_start_s,
    input  logic                draw_bg_s,
    input  logic                draw_hunger_bubble_s,
    input  logic                draw_bored_bubble_s,
    input  logic                draw_sick_bubble_s,
    input  logic                draw_dirty_bubble_s,
    input  logic                draw_dying_bubble_s,
    input  logic                draw_zzzs_s,
    input  logic                draw_food_s,
    input  logic                draw_pills_s,
    input  logic                draw_first_aid_s,
    input  logic                draw_broom_s,
    input  logic                draw_ball_s,
    input  logic [7:0]          obj_x,
    input  logic [6:0]          obj_y,
    output logic [3:0]          rom_sel,
    output logic [14:0]         rom_addr,
    input  logic [COLOUR_W-1:0] rom_data,
    output logic [7:0]          vga_x,
    output logic [6:0]          vga_y,
    output logic [COLOUR_W-1:0] vga_colour,
    output logic                vga_plot,
    output logic                plot_done,
    output logic                busy
);

    logic [NumReq-1:0] req;
    assign req = {draw_ball_s, draw_broom_s, draw_first_aid_s, draw_pills_s, draw_food_s,
                  draw_zzzs_s, draw_dying_bubble_s, draw_dirty_bubble_s, draw_sick_bubble_s,
                  draw_bored_bubble_s, draw_hunger_bubble_s, draw_bg_s, draw_start_s};

    // Lowest-numbered active request wins.
    sprite_id_e req_id;
    always_comb begin
        req_id = SprStart;
        for (int i = 12; i >= 0; i--) begin
            if (req[i]) req_id = sprite_id_e'(4'(i));
        end
    end

    logic [7:0] geom_w;
    logic [6:0] geom_h;
    logic [7:0] geom_bx;
    logic [6:0] geom_by;
    logic       geom_opaque;

    sprite_geom #(
        .BUBBLE_X (BUBBLE_X),
        .BUBBLE_Y (BUBBLE_Y)
    ) u_geom (
        .id_i     (req_id),
        .obj_x_i  (obj_x),
        .obj_y_i  (obj_y),
        .width_o  (geom_w),
        .height_o (geom_h),
        .base_x_o (geom_bx),
        .base_y_o (geom_by),
        .opaque_o (geom_opaque)
    );

    plot_state_e state_q;
    sprite_id_e  id_q;
    logic [7:0]  w_q;
    logic [6:0]  h_q;
    logic [7:0]  base_x_q;
    logic [6:0]  base_y_q;
    logic        opaque_q;
    logic [7:0]  col_q;
    logic [6:0]  row_q;
    logic [14:0] addr_q;
    logic        flush_q;

    // Control FSM and pixel walk. addr_q tracks row*width+col incrementally.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            id_q     <= SprStart;
            w_q      <= '0;
            h_q      <= '0;
            base_x_q <= '0;
            base_y_q <= '0;
            opaque_q <= 1'b0;
            col_q    <= '0;
            row_q    <= '0;
            addr_q   <= '0;
            flush_q  <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (|req) begin
                        id_q     <= req_id;
                        w_q      <= geom_w;
                        h_q      <= geom_h;
                        base_x_q <= geom_bx;
                        base_y_q <= geom_by;
                        opaque_q <= geom_opaque;
                        col_q    <= '0;
                        row_q    <= '0;
                        addr_q   <= '0;
                        state_q  <= StRun;
                    end
                end
                StRun: begin
                    if (col_q == w_q - 8'd1) begin
                        col_q <= '0;
                        if (row_q == h_q - 7'd1) begin
                            flush_q <= 1'b0;
                            state_q <= StFlush;
                        end else begin
                            row_q  <= row_q + 7'd1;
                            addr_q <= addr_q + 15'd1;
                        end
                    end else begin
                        col_q  <= col_q + 8'd1;
                        addr_q <= addr_q + 15'd1;
                    end
                end
                StFlush: begin
                    if (flush_q) state_q <= StDone;
                    else         flush_q <= 1'b1;
                end
                StDone: begin
                    state_q <= StRelease;
                end
                StRelease: begin
                    // A request still held from the finished sprite must not retrigger.
                    if (!(|req)) state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Two-stage pixel pipeline: stage 1 pairs col/row with the ROM read in flight,
    // stage 2 registers the VGA write once rom_data has arrived.
    logic                s1_valid_q;
    logic [7:0]          s1_col_q;
    logic [6:0]          s1_row_q;
    logic [7:0]          vga_x_q;
    logic [6:0]          vga_y_q;
    logic [COLOUR_W-1:0] vga_colour_q;
    logic                vga_plot_q;

    logic [8:0] x_sum;
    logic [7:0] y_sum;
    logic       clipped;
    logic       keyed;

    assign x_sum   = {1'b0, base_x_q} + {1'b0, s1_col_q};
    assign y_sum   = {1'b0, base_y_q} + {1'b0, s1_row_q};
    assign clipped = (x_sum >= 9'(ScreenW)) || (y_sum >= 8'(ScreenH));
    assign keyed   = !opaque_q && (rom_data == TRANSPARENT);

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q   <= 1'b0;
            s1_col_q     <= '0;
            s1_row_q     <= '0;
            vga_x_q      <= '0;
            vga_y_q      <= '0;
            vga_colour_q <= '0;
            vga_plot_q   <= 1'b0;
        end else begin
            s1_valid_q   <= (state_q == StRun);
            s1_col_q     <= col_q;
            s1_row_q     <= row_q;
            vga_x_q      <= x_sum[7:0];
            vga_y_q      <= y_sum[6:0];
            vga_colour_q <= rom_data;
            vga_plot_q   <= s1_valid_q && !clipped && !keyed;
        end
    end

    assign rom_sel    = id_q;
    assign rom_addr   = addr_q;
    assign vga_x      = vga_x_q;
    assign vga_y      = vga_y_q;
    assign vga_colour = vga_colour_q;
    assign vga_plot   = vga_plot_q;
    assign plot_done  = (state_q == StDone);
    assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_sprite_plotter.sv
// Self-checking bench for sprite_plotter: a behavioural ROM and a reference
// model that lists every visible pixel of a requested sprite, a scoreboard
// of expected pixels and completion cycles, and a monitor that checks them.
module tb_sprite_plotter;

    logic        clk = 1'b0;
    logic        reset;
    logic [12:0] req;
    logic [7:0]  obj_x;
    logic [6:0]  obj_y;
    logic [3:0]  rom_sel;
    logic [14:0] rom_addr;
    logic [8:0]  rom_data;
    logic [7:0]  vga_x;
    logic [6:0]  vga_y;
    logic [8:0]  vga_colour;
    logic        vga_plot;
    logic        plot_done;
    logic        busy;

    sprite_plotter dut (
        .clk                  (clk),
        .reset                (reset),
        .draw_start_s         (req[0]),
        .draw_bg_s            (req[1]),
        .draw_hunger_bubble_s (req[2]),
        .draw_bored_bubble_s  (req[3]),
        .draw_sick_bubble_s   (req[4]),
        .draw_dirty_bubble_s  (req[5]),
        .draw_dying_bubble_s  (req[6]),
        .draw_zzzs_s          (req[7]),
        .draw_food_s          (req[8]),
        .draw_pills_s         (req[9]),
        .draw_first_aid_s     (req[10]),
        .draw_broom_s         (req[11]),
        .draw_ball_s          (req[12]),
        .obj_x                (obj_x),
        .obj_y                (obj_y),
        .rom_sel              (rom_sel),
        .rom_addr             (rom_addr),
        .rom_data             (rom_data),
        .vga_x                (vga_x),
        .vga_y                (vga_y),
        .vga_colour           (vga_colour),
        .vga_plot             (vga_plot),
        .plot_done            (plot_done),
        .busy                 (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int x;
        int y;
        int c;
    } pix_t;

    pix_t exp_q[$];
    int   done_q[$];
    int   checks = 0;
    int   fails = 0;
    int   cyc = 0;
    int   mode = 0;
    logic prev_done = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // ROM contents as a function of mode, sprite and address.
    function automatic logic [8:0] rom_fn(input int m, input int s, input int a);
        int v;
        if (m == 0) begin
            v = a;
        end else if (m == 1) begin
            v = (a % 2 == 0) ? 511 : a;
        end else begin
            v = a * 37 + s * 101;
            if (v % 7 == 0) v = 511;
        end
        return v[8:0];
    endfunction

    always @(posedge clk) rom_data <= rom_fn(mode, int'(rom_sel), int'(rom_addr));

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Reference model: pushes every pixel that should reach the screen, in raster
    // order, plus the cycle at which plot_done must appear.
    task automatic plan(input logic [12:0] r, input int ox, input int oy);
        int id, w, h, bx, by, x, y, a, c;
        bit opq;
        id = 0;
        for (int i = 12; i >= 0; i--) if (r[i]) id = i;
        if (id < 2) begin
            w = 160; h = 120; bx = 0; by = 0; opq = 1;
        end else if (id < 8) begin
            w = 32; h = 32; bx = 100; by = 20; opq = 0;
        end else begin
            w = 16; h = 16; bx = ox; by = oy; opq = 0;
        end
        for (int row = 0; row < h; row++) begin
            for (int col = 0; col < w; col++) begin
                a = row * w + col;
                c = int'(rom_fn(mode, id, a));
                x = bx + col;
                y = by + row;
                if (x < 160 && y < 120 && (opq || c != 511)) exp_q.push_back('{x, y, c});
            end
        end
        done_q.push_back(cyc + w * h + 3);
    endtask

    // Monitor: compares every VGA write and every completion pulse.
    always @(negedge clk) begin
        if (vga_plot) begin
            checks++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_plot: got (%0d,%0d) c=%0h, expected no pixel",
                         vga_x, vga_y, vga_colour);
            end else begin
                pix_t p;
                p = exp_q.pop_front();
                if (int'(vga_x) != p.x || int'(vga_y) != p.y || int'(vga_colour) != p.c) begin
                    fails++;
                    $display("FAIL pixel: got (%0d,%0d) c=%0h, expected (%0d,%0d) c=%0h",
                             vga_x, vga_y, vga_colour, p.x, p.y, p.c);
                end
            end
        end
        if (plot_done) begin
            if (done_q.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                chk("done_cycle", cyc, done_q.pop_front());
                chk("pixels_left_at_done", exp_q.size(), 0);
            end
            if (prev_done) chk("done_consecutive", 1, 0);
        end
        prev_done = plot_done;
    end

    task automatic draw(input logic [12:0] r, input int ox, input int oy, input int m,
                        input int hold, input bit wiggle);
        int n;
        @(negedge clk);
        mode  = m;
        obj_x = 8'(ox);
        obj_y = 7'(oy);
        plan(r, ox, oy);
        req = r;
        n = 0;
        while (!plot_done && n < 20000) begin
            @(negedge clk);
            if (wiggle) begin
                obj_x = 8'($urandom);
                obj_y = 7'($urandom);
            end
            n++;
        end
        if (!plot_done) begin
            chk("done_timeout", 0, 1);
            done_q.delete();
            exp_q.delete();
        end
        @(negedge clk);
        chk("done_pulse_width", int'(plot_done), 0);
        for (int i = 0; i < hold; i++) begin
            chk("busy_while_held", int'(busy), 1);
            @(negedge clk);
        end
        req = '0;
        @(negedge clk);
        chk("idle_after_release", int'(busy), 0);
    endtask

    task automatic chk_reset_outputs();
        chk("rst_vga_x", int'(vga_x), 0);
        chk("rst_vga_y", int'(vga_y), 0);
        chk("rst_vga_colour", int'(vga_colour), 0);
        chk("rst_vga_plot", int'(vga_plot), 0);
        chk("rst_plot_done", int'(plot_done), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_rom_sel", int'(rom_sel), 0);
        chk("rst_rom_addr", int'(rom_addr), 0);
    endtask

    initial begin
        reset = 1'b1;
        req   = '0;
        obj_x = '0;
        obj_y = '0;
        repeat (3) @(negedge clk);
        chk_reset_outputs();
        reset = 1'b0;

        // Full-screen background, opaque: the key colour is plotted too.
        draw(13'h0002, 0, 0, 0, 0, 1'b0);
        // Hunger bubble, every even address transparent.
        draw(13'h0004, 0, 0, 1, 0, 1'b0);
        // Ball clipped at the bottom-right corner.
        draw(13'h1000, 150, 110, 2, 0, 1'b0);
        // Request held long after completion, then a fresh item.
        draw(13'h0080, 0, 0, 2, 50, 1'b0);
        draw(13'h0100, 40, 60, 0, 0, 1'b0);

        // Reset in the middle of a full-screen draw.
        @(negedge clk);
        mode = 2;
        plan(13'h0001, 0, 0);
        req = 13'h0001;
        repeat (40) @(negedge clk);
        #1;
        reset = 1'b1;
        req   = '0;
        @(negedge clk);
        chk_reset_outputs();
        exp_q.delete();
        done_q.delete();
        reset = 1'b0;
        repeat (30) @(negedge clk);
        chk("idle_after_reset", int'(busy), 0);
        draw(13'h0001, 0, 0, 2, 0, 1'b0);

        // Sick bubble beats pills; item position wiggles during the walk.
        draw(13'h0210, 5, 5, 1, 0, 1'b1);

        // Random bubbles and items.
        for (int i = 0; i < 8; i++) begin
            logic [12:0] r;
            r = 13'd1 << $urandom_range(12, 2);
            draw(r, int'($urandom_range(255, 0)), int'($urandom_range(127, 0)),
                 int'($urandom_range(2, 0)), int'($urandom_range(3, 0)), 1'b0);
        end

        repeat (5) @(negedge clk);
        chk("pixels_left_end", exp_q.size(), 0);
        chk("dones_left_end", done_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
